mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage and MEM/WB pipeline register. It is the receiving end of the execute-stage outputs (ALUResult_M, Rd2_M, Rd_M and the M-stage control bits). It drives a variable-latency data-memory request/response interface and stalls the upstream pipeline while an access is outstanding. It registers the writeback result, destination register and write-enable for the W stage; Result_W also feeds back to the execute stage forwarding muxes.

Parameters:
ADDR_BITS, 10, width of dmem_addr; taken from ALUResult_M[ADDR_BITS-1:0] as a byte address.
TIMEOUT_CYCLES, 15, maximum wait cycles for ready/rvalid (used only with MEM_TIMEOUT_EN).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
RegWrite_M  input  1  instruction writes rd
MemWrite_M  input  1  store
MemRead_M  input  1  load
MemToReg_M  input  1  writeback selects load data, else ALU result
ALUResult_M  input  32  ALU result / memory byte address
Rd2_M  input  32  store data
Rd_M  input  5  destination register
dmem_req  output  1  memory request valid
dmem_we  output  1  1=write, 0=read
dmem_addr  output  ADDR_BITS  byte address
dmem_wdata  output  32  store data
dmem_ready  input  1  memory accepts request this cycle
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data
stall_M  output  1  hold M-stage inputs and all upstream stages
Result_W  output  32  writeback value (also forwarded to EX)
RegWrite_W  output  1  writeback enable
Rd_W  output  5  writeback register
bus_err_W  output  1  access timed out (MEM_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE; Result_W=0, RegWrite_W=0, Rd_W=0, bus_err_W=0; internal timeout counter=0. dmem_req=0 while reset is asserted.
- States: IDLE, REQ (request not yet accepted), WAIT_RESP (read accepted, data pending).
- mem_op = MemRead_M | MemWrite_M. If both are high, treat the instruction as a read.
- dmem_req is combinational: 1 in IDLE when mem_op=1, and 1 in REQ. It is 0 in WAIT_RESP.
- dmem_we = MemWrite_M & ~MemRead_M. dmem_addr = ALUResult_M[ADDR_BITS-1:0]. dmem_wdata = Rd2_M. These are combinational from the M inputs, which upstream holds stable while stall_M=1.
- Request acceptance: the request is accepted at a rising edge where dmem_req=1 and dmem_ready=1.
  - Accepted write: the access completes in that cycle.
  - Accepted read: the access completes in that cycle only if dmem_rvalid=1 as well; otherwise the next state is WAIT_RESP.
  - Not accepted: the next state is REQ and the request is held; exactly one transaction per instruction.
- WAIT_RESP: completes in the cycle where dmem_rvalid=1, then returns to IDLE.
- dmem_rvalid is ignored whenever no read is outstanding, including IDLE with no request and after a reset.
- stall_M = (mem_op & ~complete_this_cycle), evaluated in IDLE, REQ and WAIT_RESP. It is combinational, and 0 for non-memory instructions.
- W register update at each rising edge:
  - When stall_M=0: RegWrite_W<=RegWrite_M, Rd_W<=Rd_M, Result_W <= MemToReg_M ? load_data : ALUResult_M. load_data is dmem_rdata in the completing cycle.
  - When stall_M=1: RegWrite_W<=0 (bubble), while Rd_W and Result_W hold.
- Latency: non-memory ops and zero-wait accesses take 1 cycle to reach W. A read with N-cycle rvalid latency stalls for N cycles.
- Back-to-back memory ops: a new request may be issued in the cycle immediately after completion, with no idle cycle.
- Reset mid-access: immediately abandon, return to IDLE, and deassert dmem_req. The memory side is responsible for discarding any in-flight response.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle the FSM is in REQ or WAIT_RESP without completing, and clears on completion or reset.
  - On reaching TIMEOUT_CYCLES, the access is aborted: the FSM goes to IDLE, stall_M=0 for that cycle, RegWrite_W<=0, Result_W<=0, and bus_err_W<=1 for one cycle.
  - A response arriving after the abort is ignored.
- Not defined: no counter, bus_err_W is constant 0, and the FSM waits indefinitely.

Test Plan:
- ALU op: RegWrite_M=1, Rd_M=5, ALUResult_M=0x2A, MemToReg_M=0 -> dmem_req=0, stall_M=0; next edge Rd_W=5, Result_W=0x2A, RegWrite_W=1.
- Zero-wait store: MemWrite_M=1, ALUResult_M=0x010, Rd2_M=0xCAFEF00D, dmem_ready=1 -> dmem_req=1, dmem_we=1, dmem_addr=0x010, dmem_wdata=0xCAFEF00D, stall_M=0; next RegWrite_W=0.
- Store with dmem_ready low 2 cycles -> stall_M=1 for 2 cycles, dmem_req held for 3 cycles, exactly one accepted write, RegWrite_W=0 throughout.
- Load with RegWrite_M=1, MemToReg_M=1, Rd_M=7, accepted in cycle 0, rvalid in cycle 3 with rdata=0x12345678 -> stall_M=1 in cycles 0-2; after the cycle-3 edge Result_W=0x12345678, Rd_W=7, RegWrite_W=1 for one cycle.
- Reset asserted while in WAIT_RESP -> all outputs 0 and dmem_req=0 immediately; a later rvalid causes no RegWrite_W pulse.
- MEM_TIMEOUT_EN: load accepted, no rvalid for 15 cycles -> bus_err_W=1 for one cycle, RegWrite_W=0, stall_M released, FSM in IDLE.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access stage plus the MEM/WB pipeline register. Drives a
//   variable-latency data-memory request/response port. Holds the upstream
//   pipeline (stall_M) while an access is outstanding. Registers the
//   writeback value, destination and write-enable for the W stage.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     When defined, an access left waiting in REQ/WAIT_RESP for
//     TIMEOUT_CYCLES cycles is aborted and flagged on bus_err_W for one cycle.
//     When undefined, bus_err_W is tied 0 and the FSM waits indefinitely.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   RegWrite_M         M-stage instruction writes rd
//   MemWrite_M         store
//   MemRead_M          load (wins over MemWrite_M when both are set)
//   MemToReg_M         writeback selects load data, else ALU result
//   ALUResult_M        ALU result / memory byte address
//   Rd2_M              store data
//   Rd_M               destination register
//   dmem_req           memory request valid (combinational)
//   dmem_we            1 = write, 0 = read
//   dmem_addr          byte address (low ADDR_BITS of ALUResult_M)
//   dmem_wdata         store data
//   dmem_ready         memory accepts the request this cycle
//   dmem_rvalid        read data valid
//   dmem_rdata         read data
//   stall_M            hold M-stage inputs and all upstream stages
//   Result_W           writeback value, also forwarded to EX
//   RegWrite_W         writeback enable
//   Rd_W               writeback register
//   bus_err_W          access timed out (MEM_TIMEOUT_EN only)

module mem_wb_stage #(
    parameter int unsigned ADDR_BITS      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite_M,
    input  logic                 MemWrite_M,
    input  logic                 MemRead_M,
    input  logic                 MemToReg_M,
    input  logic [31:0]          ALUResult_M,
    input  logic [31:0]          Rd2_M,
    input  logic [4:0]           Rd_M,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_BITS-1:0] dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic                 stall_M,
    output logic [31:0]          Result_W,
    output logic                 RegWrite_W,
    output logic [4:0]           Rd_W,
    output logic                 bus_err_W
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic mem_op;
    logic accept;
    logic complete;
    logic abort;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT_CYCLES must be at least 1");
    end

    assign mem_op     = MemRead_M | MemWrite_M;
    assign dmem_we    = MemWrite_M & ~MemRead_M;
    assign dmem_addr  = ALUResult_M[ADDR_BITS-1:0];
    assign dmem_wdata = Rd2_M;

    // Request is live when a new access arrives in IDLE or one is being
    // retried in REQ; masked during reset so an abandoned access vanishes
    // immediately.
    assign dmem_req = ~reset & (((state == IDLE) & mem_op) | (state == REQ));

    // ------------------------------------------------------------------
    // Optional timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // The cycle that would be the TIMEOUT_CYCLES-th waiting cycle aborts
    // instead of waiting.
    assign abort = (state != IDLE) & ~complete
                 & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state != IDLE) && !complete && !abort) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign abort     = 1'b0;
    assign bus_err_W = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE, REQ: begin
                if (dmem_req) begin
                    accept = dmem_ready;
                    // Reads only complete on acceptance when data is
                    // returned in the same cycle.
                    complete = dmem_ready & (dmem_we | dmem_rvalid);
                    if (!accept) begin
                        state_next = REQ;
                    end else if (complete) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                complete = dmem_rvalid;
                if (dmem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    assign stall_M = ~reset & mem_op & ~complete & ~abort;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Result_W   <= '0;
            RegWrite_W <= 1'b0;
            Rd_W       <= '0;
`ifdef MEM_TIMEOUT_EN
            bus_err_W  <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            bus_err_W <= abort;
`endif
            if (abort) begin
                RegWrite_W <= 1'b0;
                Result_W   <= '0;
            end else if (stall_M) begin
                // Bubble: destination and value hold so forwarding stays sane.
                RegWrite_W <= 1'b0;
            end else begin
                RegWrite_W <= RegWrite_M;
                Rd_W       <= Rd_M;
                Result_W   <= MemToReg_M ? dmem_rdata : ALUResult_M;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage (default build, MEM_TIMEOUT_EN undefined).
// Inputs change 1 time unit after the rising edge; outputs are checked after that.

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_M, MemWrite_M, MemRead_M, MemToReg_M;
    logic [31:0] ALUResult_M, Rd2_M;
    logic [4:0]  Rd_M;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_M;
    logic [31:0] Result_W;
    logic        RegWrite_W;
    logic [4:0]  Rd_W;
    logic        bus_err_W;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_accepts = 0;
    int unsigned req_cycles = 0;
    int unsigned stall_cycles = 0;
    int unsigned base;

    mem_wb_stage #(
        .ADDR_BITS(10),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .RegWrite_M(RegWrite_M),
        .MemWrite_M(MemWrite_M),
        .MemRead_M(MemRead_M),
        .MemToReg_M(MemToReg_M),
        .ALUResult_M(ALUResult_M),
        .Rd2_M(Rd2_M),
        .Rd_M(Rd_M),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .stall_M(stall_M),
        .Result_W(Result_W),
        .RegWrite_W(RegWrite_W),
        .Rd_W(Rd_W),
        .bus_err_W(bus_err_W)
    );

    always #5 clk = ~clk;

    // Inputs are stable from edge+1 to the next edge, so negedge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (dmem_req && dmem_ready && dmem_we) wr_accepts++;
        if (dmem_req) req_cycles++;
        if (stall_M) stall_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite_M  = 1'b0;
        MemWrite_M  = 1'b0;
        MemRead_M   = 1'b0;
        MemToReg_M  = 1'b0;
        ALUResult_M = '0;
        Rd2_M       = '0;
        Rd_M        = '0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        // Memory op presented during reset must not reach the bus.
        MemRead_M  = 1'b1;
        dmem_ready = 1'b1;
        #12;
        check("rst_req",      {31'd0, dmem_req},   32'd0);
        check("rst_stall",    {31'd0, stall_M},    32'd0);
        check("rst_result",   Result_W,            32'd0);
        check("rst_regwrite", {31'd0, RegWrite_W}, 32'd0);
        check("rst_rd",       {27'd0, Rd_W},       32'd0);
        check("rst_buserr",   {31'd0, bus_err_W},  32'd0);
        tick();
        idle_inputs();
        reset = 1'b0;

        // ALU op
        RegWrite_M = 1'b1; Rd_M = 5'd5; ALUResult_M = 32'h2A;
        #1;
        check("alu_req",   {31'd0, dmem_req}, 32'd0);
        check("alu_stall", {31'd0, stall_M},  32'd0);
        tick();
        check("alu_rd_w",  {27'd0, Rd_W},       32'd5);
        check("alu_res_w", Result_W,            32'h2A);
        check("alu_rw_w",  {31'd0, RegWrite_W}, 32'd1);

        // Zero-wait store
        idle_inputs();
        MemWrite_M = 1'b1; ALUResult_M = 32'h010; Rd2_M = 32'hCAFEF00D; dmem_ready = 1'b1;
        #1;
        check("st0_req",   {31'd0, dmem_req}, 32'd1);
        check("st0_we",    {31'd0, dmem_we},  32'd1);
        check("st0_addr",  {22'd0, dmem_addr}, 32'h010);
        check("st0_wdata", dmem_wdata,         32'hCAFEF00D);
        check("st0_stall", {31'd0, stall_M},   32'd0);
        tick();
        check("st0_rw_w",  {31'd0, RegWrite_W}, 32'd0);
        check("st0_res_w", Result_W,            32'h010);

        // Store, ready low for 2 cycles, back-to-back with the previous store
        base = wr_accepts;
        req_cycles = 0;
        stall_cycles = 0;
        ALUResult_M = 32'hFFFF_F3FC; Rd2_M = 32'h1111_2222; dmem_ready = 1'b0;
        #1;
        check("stw_req0",  {31'd0, dmem_req}, 32'd1);
        check("stw_addr",  {22'd0, dmem_addr}, 32'h3FC);
        check("stw_stall0", {31'd0, stall_M},  32'd1);
        tick();
        check("stw_rw_w0", {31'd0, RegWrite_W}, 32'd0);
        check("stw_stall1", {31'd0, stall_M},  32'd1);
        tick();
        check("stw_rw_w1", {31'd0, RegWrite_W}, 32'd0);
        dmem_ready = 1'b1;
        #1;
        check("stw_req2",   {31'd0, dmem_req}, 32'd1);
        check("stw_stall2", {31'd0, stall_M},  32'd0);
        tick();
        idle_inputs();
        check("stw_rw_w2",   {31'd0, RegWrite_W}, 32'd0);
        check("stw_accepts", wr_accepts - base,   32'd1);
        check("stw_reqcyc",  req_cycles,          32'd3);
        check("stw_stallcyc", stall_cycles,       32'd2);

        // Load, accepted in cycle 0, rvalid in cycle 3
        RegWrite_M = 1'b1; MemToReg_M = 1'b1; MemRead_M = 1'b1; Rd_M = 5'd7;
        ALUResult_M = 32'h020; dmem_ready = 1'b1;
        #1;
        check("ld_req0",   {31'd0, dmem_req}, 32'd1);
        check("ld_we0",    {31'd0, dmem_we},  32'd0);
        check("ld_stall0", {31'd0, stall_M},  32'd1);
        tick();
        dmem_ready = 1'b0;
        #1;
        check("ld_rw_w1",  {31'd0, RegWrite_W}, 32'd0);
        check("ld_req1",   {31'd0, dmem_req},   32'd0);
        check("ld_stall1", {31'd0, stall_M},    32'd1);
        tick();
        check("ld_stall2", {31'd0, stall_M},    32'd1);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        check("ld_stall3", {31'd0, stall_M},    32'd0);
        tick();
        check("ld_res_w",  Result_W,            32'h12345678);
        check("ld_rd_w",   {27'd0, Rd_W},       32'd7);
        check("ld_rw_w",   {31'd0, RegWrite_W}, 32'd1);
        idle_inputs();
        tick();
        check("ld_rw_pulse", {31'd0, RegWrite_W}, 32'd0);

        // Read and write both set: a zero-wait read
        RegWrite_M = 1'b1; MemToReg_M = 1'b1; MemRead_M = 1'b1; MemWrite_M = 1'b1;
        Rd_M = 5'd9; ALUResult_M = 32'h044; dmem_ready = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("rw_we",    {31'd0, dmem_we},  32'd0);
        check("rw_req",   {31'd0, dmem_req}, 32'd1);
        check("rw_stall", {31'd0, stall_M},  32'd0);
        tick();
        check("rw_res_w", Result_W,            32'hDEADBEEF);
        check("rw_rd_w",  {27'd0, Rd_W},       32'd9);
        check("rw_rw_w",  {31'd0, RegWrite_W}, 32'd1);

        // rvalid with nothing outstanding is ignored
        idle_inputs();
        RegWrite_M = 1'b1; Rd_M = 5'd4; ALUResult_M = 32'h55;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000FFFF;
        #1;
        check("ign_stall", {31'd0, stall_M}, 32'd0);
        tick();
        check("ign_res_w", Result_W, 32'h55);
        // Load not yet accepted: stray rvalid must not complete it
        MemRead_M = 1'b1; MemToReg_M = 1'b1; Rd_M = 5'd6; ALUResult_M = 32'h008;
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h777;
        #1;
        check("ign_stall_req", {31'd0, stall_M}, 32'd1);
        tick();
        check("ign_rw_w",   {31'd0, RegWrite_W}, 32'd0);
        check("ign_hold_w", Result_W,            32'h55);
        dmem_ready = 1'b1; dmem_rvalid = 1'b0;
        #1;
        check("ign_req_retry", {31'd0, dmem_req}, 32'd1);
        check("ign_stall_acc", {31'd0, stall_M},  32'd1);
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BADF00D;
        #1;
        check("ign_stall_done", {31'd0, stall_M}, 32'd0);
        tick();
        check("ign_ld_res", Result_W,            32'h0BADF00D);
        check("ign_ld_rd",  {27'd0, Rd_W},       32'd6);
        check("ign_ld_rw",  {31'd0, RegWrite_W}, 32'd1);

        // Reset while in WAIT_RESP
        idle_inputs();
        RegWrite_M = 1'b1; MemToReg_M = 1'b1; MemRead_M = 1'b1; Rd_M = 5'd3;
        ALUResult_M = 32'h0C0; dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        #1;
        check("mr_wait_stall", {31'd0, stall_M}, 32'd1);
        reset = 1'b1;
        #1;
        check("mr_req",    {31'd0, dmem_req},   32'd0);
        check("mr_stall",  {31'd0, stall_M},    32'd0);
        check("mr_res_w",  Result_W,            32'd0);
        check("mr_rw_w",   {31'd0, RegWrite_W}, 32'd0);
        check("mr_rd_w",   {27'd0, Rd_W},       32'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h00000BAD;
        #1;
        check("mr_late_stall", {31'd0, stall_M},  32'd0);
        check("mr_late_req",   {31'd0, dmem_req}, 32'd0);
        tick();
        check("mr_late_rw", {31'd0, RegWrite_W}, 32'd0);
        check("mr_late_res", Result_W,           32'd0);
        dmem_rvalid = 1'b0;
        tick();
        check("mr_late_rw2", {31'd0, RegWrite_W}, 32'd0);
        check("buserr_off",  {31'd0, bus_err_W},  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
